fetch_redirect_ctrl: RTL and testbench
======================================

FETCH_REDIRECT_CTRL -- requirements
Module: fetch_redirect_ctrl

Interface
REQ-001 SHALL have parameter SQUASH_CYCLES, default 2, legal range 1..7: cycles after a redirect during which predictor hits are suppressed.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_stall  input  1  fetch back-pressure; PC must hold.
REQ-005 SHALL have port i_mispred  input  1  branch-unit mispredict redirect request.
REQ-006 SHALL have port i_mispred_addr  input  `RV32_PC_WIDTH  correct target for i_mispred.
REQ-007 SHALL have port i_pred_jmp  input  1  predictor taken-jump hint for the current fetch PC.
REQ-008 SHALL have port i_pred_jmpaddr  input  `RV32_PC_WIDTH  predicted target.
REQ-009 SHALL have ports i_trap (input, 1) and i_trap_vec (input, `RV32_PC_WIDTH), present only under REQ-030: trap redirect and vector.
REQ-010 SHALL have outputs o_pc_stall (1), o_pc_miss (1) and o_pc_jmpaddr (`RV32_PC_WIDTH): PC-register stall, forced load and load address.
REQ-011 SHALL have outputs o_pred_jmp (1) and o_pred_jmpaddr (`RV32_PC_WIDTH): filtered prediction driven to the PC register.
REQ-012 SHALL have outputs o_flush (1), one-cycle kill of all younger fetch/decode entries, and o_busy (1), high whenever state is not RUN.

Function
REQ-013 SHALL implement states RUN, HOLD (redirect pending under stall) and SQUASH (post-redirect prediction mask).
REQ-014 Redirect priority SHALL be trap > mispred > pred, evaluated every cycle.
REQ-015 RUN, redirect request with i_stall=0: SHALL drive o_pc_miss=1, o_pc_jmpaddr=winning address, o_flush=1 in the same cycle (0 latency), then enter SQUASH with counter=SQUASH_CYCLES.
REQ-016 RUN, redirect request with i_stall=1: SHALL capture winner address and source into a pending register, keep o_pc_miss=0 and o_flush=0, and enter HOLD.
REQ-017 HOLD: a later request of strictly higher priority SHALL overwrite the pending entry; equal or lower priority SHALL be ignored.
REQ-018 HOLD, first cycle with i_stall=0: SHALL issue the pending redirect per REQ-015, or the new request if higher priority that cycle, then clear pending.
REQ-019 SQUASH: o_pred_jmp SHALL be forced 0; counter decrements on each non-stalled cycle; on reaching 0 the state returns to RUN.
REQ-020 SQUASH, new trap/mispred: SHALL behave as REQ-015/REQ-016 and reload the counter to SQUASH_CYCLES.
REQ-021 RUN with no redirect: o_pred_jmp=i_pred_jmp&~i_stall, o_pred_jmpaddr=i_pred_jmpaddr; a prediction during stall SHALL be dropped, not queued.
REQ-022 o_pc_stall SHALL equal i_stall, except 0 in any cycle where o_pc_miss=1.
REQ-023 o_pc_miss and o_pred_jmp SHALL never be high in the same cycle.
REQ-024 o_flush SHALL be high for exactly one cycle per issued redirect; never for predictions.
REQ-025 Counter SHALL be 3 bits and SHALL never wrap below 0.

Reset
REQ-026 rst_n low SHALL asynchronously force state RUN, counter 0, pending cleared.
REQ-027 During reset all outputs SHALL be 0 (o_pc_jmpaddr and o_pred_jmpaddr 0).
REQ-028 Reset deassertion mid-HOLD or mid-SQUASH SHALL discard the pending redirect; first post-reset cycle behaves as RUN.
REQ-029 rst_n SHALL be synchronized externally for deassertion; the block adds no synchronizer.

Configuration
REQ-030 Macro FETCH_REDIRECT_TRAP_EN defined: i_trap/i_trap_vec exist and trap is the top-priority source; undefined: ports absent, trap logic removed, priority is mispred > pred, all other behaviour unchanged.

Verification
REQ-031 Mispred, no stall: i_mispred=1, addr=0x0000_1000 -> same cycle o_pc_miss=1, o_pc_jmpaddr=0x1000, o_flush=1; next 2 cycles i_pred_jmp=1 -> o_pred_jmp=0.
REQ-032 Mispred under stall: i_stall=1 for 3 cycles, i_mispred pulse addr=0x200 in cycle 1 -> o_pc_miss=0 while stalled, o_busy=1; first unstalled cycle o_pc_miss=1, o_pc_jmpaddr=0x200.
REQ-033 Priority in HOLD (TRAP_EN): pending mispred 0x200, then i_trap vec=0x80 while stalled -> after unstall o_pc_jmpaddr=0x80; reverse order keeps 0x80.
REQ-034 Squash restart: mispred 0x100, one cycle later mispred 0x300 -> two o_flush pulses, mask lasts SQUASH_CYCLES cycles after the second.
REQ-035 Reset mid-HOLD: pending 0x200, assert rst_n=0 asynchronously -> outputs 0 immediately; after release no redirect issued, o_busy=0.

Source files
------------

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl
//   Arbitrates PC redirects for the fetch stage. Trap and mispredict
//   redirects load the PC and flush younger fetch/decode entries. A
//   redirect that arrives during a stall is held until the stall lifts.
//   For SQUASH_CYCLES unstalled cycles after each redirect, predictor
//   taken-hints are masked.
//
//   Optional feature: define FETCH_REDIRECT_TRAP_EN to add the trap
//   source (i_trap / i_trap_vec). A trap has priority over a mispredict.
//
//   Ports
//     clk, rst_n      clock; asynchronous active-low reset
//     i_stall         fetch back-pressure; the PC must hold
//     i_mispred(_addr) mispredict redirect request and its target
//     i_pred_jmp(addr) predictor taken-hint and its target
//     i_trap(_vec)    trap redirect and its vector (only with the macro)
//     o_pc_stall      PC-register stall
//     o_pc_miss       forced PC load
//     o_pc_jmpaddr    address for the forced PC load
//     o_pred_jmp      filtered predictor hint
//     o_pred_jmpaddr  target for the filtered predictor hint
//     o_flush         one-cycle kill of all younger entries
//     o_busy          high whenever the controller is not in RUN
`ifndef RV32_PC_WIDTH
`define RV32_PC_WIDTH 32
`endif

module fetch_redirect_ctrl #(
  parameter int SQUASH_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_stall,
  input  logic                      i_mispred,
  input  logic [`RV32_PC_WIDTH-1:0] i_mispred_addr,
  input  logic                      i_pred_jmp,
  input  logic [`RV32_PC_WIDTH-1:0] i_pred_jmpaddr,
`ifdef FETCH_REDIRECT_TRAP_EN
  input  logic                      i_trap,
  input  logic [`RV32_PC_WIDTH-1:0] i_trap_vec,
`endif
  output logic                      o_pc_stall,
  output logic                      o_pc_miss,
  output logic [`RV32_PC_WIDTH-1:0] o_pc_jmpaddr,
  output logic                      o_pred_jmp,
  output logic [`RV32_PC_WIDTH-1:0] o_pred_jmpaddr,
  output logic                      o_flush,
  output logic                      o_busy
);

  localparam int W = `RV32_PC_WIDTH;
  localparam logic [2:0] SQ_LOAD = 3'(SQUASH_CYCLES);

  // Source encoding doubles as priority: a larger value wins.
  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_MISP = 2'd1;
  localparam logic [1:0] SRC_TRAP = 2'd2;

  typedef enum logic [1:0] {RUN, HOLD, SQUASH} state_t;

  state_t         state_reg, state_next;
  logic [2:0]     cnt_reg, cnt_next;
  logic [1:0]     pend_src_reg, pend_src_next;
  logic [W-1:0]   pend_addr_reg, pend_addr_next;

  logic [1:0]     req_src;
  logic [W-1:0]   req_addr;
  logic [1:0]     win_src;
  logic [W-1:0]   win_addr;
  logic           miss_c, flush_c, pred_c;
  logic [W-1:0]   jmpaddr_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RUN;
      cnt_reg       <= 3'd0;
      pend_src_reg  <= SRC_NONE;
      pend_addr_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      pend_src_reg  <= pend_src_next;
      pend_addr_reg <= pend_addr_next;
    end
  end

  // Highest-priority redirect requested in this cycle.
  always_comb begin
    req_src  = SRC_NONE;
    req_addr = '0;
`ifdef FETCH_REDIRECT_TRAP_EN
    if (i_trap) begin
      req_src  = SRC_TRAP;
      req_addr = i_trap_vec;
    end else
`endif
    if (i_mispred) begin
      req_src  = SRC_MISP;
      req_addr = i_mispred_addr;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    pend_src_next  = pend_src_reg;
    pend_addr_next = pend_addr_reg;
    miss_c         = 1'b0;
    flush_c        = 1'b0;
    pred_c         = 1'b0;
    jmpaddr_c      = '0;

    // Pending is empty outside HOLD, so this reduces to the request there.
    // Inside HOLD, only a strictly higher-priority request replaces it.
    if (req_src > pend_src_reg) begin
      win_src  = req_src;
      win_addr = req_addr;
    end else begin
      win_src  = pend_src_reg;
      win_addr = pend_addr_reg;
    end

    if (win_src != SRC_NONE) begin
      if (i_stall) begin
        pend_src_next  = win_src;
        pend_addr_next = win_addr;
        state_next     = HOLD;
      end else begin
        miss_c         = 1'b1;
        flush_c        = 1'b1;
        jmpaddr_c      = win_addr;
        pend_src_next  = SRC_NONE;
        pend_addr_next = '0;
        cnt_next       = SQ_LOAD;
        state_next     = SQUASH;
      end
    end else begin
      case (state_reg)
        RUN: pred_c = i_pred_jmp & ~i_stall;
        SQUASH: begin
          // Count only unstalled cycles; clamp at zero.
          if (!i_stall) begin
            if (cnt_reg <= 3'd1) begin
              cnt_next   = 3'd0;
              state_next = RUN;
            end else begin
              cnt_next = cnt_reg - 3'd1;
            end
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  // While reset is asserted, the outputs are forced low combinationally.
  // They therefore go to zero without waiting for a clock edge.
  assign o_pc_miss      = rst_n & miss_c;
  assign o_flush        = rst_n & flush_c;
  assign o_pc_jmpaddr   = rst_n ? jmpaddr_c : '0;
  assign o_pred_jmp     = rst_n & pred_c;
  assign o_pred_jmpaddr = rst_n ? i_pred_jmpaddr : '0;
  assign o_pc_stall     = rst_n & i_stall & ~miss_c;
  assign o_busy         = rst_n & (state_reg != RUN);

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
`ifndef RV32_PC_WIDTH
`define RV32_PC_WIDTH 32
`endif

module tb_fetch_redirect_ctrl;
  localparam int W = `RV32_PC_WIDTH;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_stall, i_mispred, i_pred_jmp;
  logic [W-1:0] i_mispred_addr, i_pred_jmpaddr;
`ifdef FETCH_REDIRECT_TRAP_EN
  logic         i_trap;
  logic [W-1:0] i_trap_vec;
`endif
  logic         o_pc_stall, o_pc_miss, o_pred_jmp, o_flush, o_busy;
  logic [W-1:0] o_pc_jmpaddr, o_pred_jmpaddr;

  int checks = 0;
  int errors = 0;

  fetch_redirect_ctrl #(.SQUASH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_stall(i_stall),
    .i_mispred(i_mispred), .i_mispred_addr(i_mispred_addr),
    .i_pred_jmp(i_pred_jmp), .i_pred_jmpaddr(i_pred_jmpaddr),
`ifdef FETCH_REDIRECT_TRAP_EN
    .i_trap(i_trap), .i_trap_vec(i_trap_vec),
`endif
    .o_pc_stall(o_pc_stall), .o_pc_miss(o_pc_miss), .o_pc_jmpaddr(o_pc_jmpaddr),
    .o_pred_jmp(o_pred_jmp), .o_pred_jmpaddr(o_pred_jmpaddr),
    .o_flush(o_flush), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_stall = 0; i_mispred = 0; i_mispred_addr = '0;
    i_pred_jmp = 0; i_pred_jmpaddr = '0;
`ifdef FETCH_REDIRECT_TRAP_EN
    i_trap = 0; i_trap_vec = '0;
`endif
  endtask

  task automatic test_reset();
    rst_n = 0; i_stall = 1; i_mispred = 1; i_mispred_addr = 32'h1234;
    i_pred_jmp = 1; i_pred_jmpaddr = 32'h55;
    #2;
    checks++; if (o_pc_miss !== 1'b0) begin errors++; $display("FAIL reset_miss got %b want 0", o_pc_miss); end
    checks++; if (o_flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b want 0", o_flush); end
    checks++; if (o_pc_jmpaddr !== 32'h0) begin errors++; $display("FAIL reset_jmpaddr got %h want 0", o_pc_jmpaddr); end
    checks++; if (o_pred_jmp !== 1'b0) begin errors++; $display("FAIL reset_pred got %b want 0", o_pred_jmp); end
    checks++; if (o_pred_jmpaddr !== 32'h0) begin errors++; $display("FAIL reset_predaddr got %h want 0", o_pred_jmpaddr); end
    checks++; if (o_pc_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", o_pc_stall); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
    step();
    idle_inputs();
    rst_n = 1;
    step();
    $display("test_reset done");
  endtask

  task automatic test_pred_run();
    i_pred_jmp = 1; i_pred_jmpaddr = 32'h44; #1;
    checks++; if (o_pred_jmp !== 1'b1) begin errors++; $display("FAIL run_pred got %b want 1", o_pred_jmp); end
    checks++; if (o_pred_jmpaddr !== 32'h44) begin errors++; $display("FAIL run_predaddr got %h want 44", o_pred_jmpaddr); end
    checks++; if (o_flush !== 1'b0 || o_pc_miss !== 1'b0) begin errors++; $display("FAIL run_pred_noflush got %b%b want 00", o_flush, o_pc_miss); end
    step();
    i_stall = 1; #1;
    checks++; if (o_pred_jmp !== 1'b0) begin errors++; $display("FAIL stall_pred got %b want 0", o_pred_jmp); end
    checks++; if (o_pc_stall !== 1'b1) begin errors++; $display("FAIL stall_pcstall got %b want 1", o_pc_stall); end
    step();
    i_stall = 0; i_pred_jmp = 0; #1;
    checks++; if (o_pred_jmp !== 1'b0) begin errors++; $display("FAIL pred_not_queued got %b want 0", o_pred_jmp); end
    step();
    $display("test_pred_run done");
  endtask

  task automatic test_mispred();
    i_mispred = 1; i_mispred_addr = 32'h1000; i_pred_jmp = 1; i_pred_jmpaddr = 32'h40; #1;
    checks++; if (o_pc_miss !== 1'b1) begin errors++; $display("FAIL misp_miss got %b want 1", o_pc_miss); end
    checks++; if (o_pc_jmpaddr !== 32'h1000) begin errors++; $display("FAIL misp_addr got %h want 1000", o_pc_jmpaddr); end
    checks++; if (o_flush !== 1'b1) begin errors++; $display("FAIL misp_flush got %b want 1", o_flush); end
    checks++; if (o_pred_jmp !== 1'b0) begin errors++; $display("FAIL misp_pred_excl got %b want 0", o_pred_jmp); end
    step();
    i_mispred = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (o_pred_jmp !== 1'b0) begin errors++; $display("FAIL squash_pred[%0d] got %b want 0", c, o_pred_jmp); end
      checks++; if (o_busy !== 1'b1 || o_flush !== 1'b0) begin errors++; $display("FAIL squash_busy[%0d] busy %b flush %b want 1 0", c, o_busy, o_flush); end
      step();
    end
    #1;
    checks++; if (o_pred_jmp !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("FAIL squash_end pred %b busy %b want 1 0", o_pred_jmp, o_busy); end
    idle_inputs();
    step();
    $display("test_mispred done");
  endtask

  task automatic test_stall_hold();
    i_stall = 1; i_mispred = 1; i_mispred_addr = 32'h200; #1;
    checks++; if (o_pc_miss !== 1'b0 || o_flush !== 1'b0) begin errors++; $display("FAIL hold_capture miss %b flush %b want 0 0", o_pc_miss, o_flush); end
    step();
    i_mispred = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (o_busy !== 1'b1 || o_pc_miss !== 1'b0) begin errors++; $display("FAIL hold_wait[%0d] busy %b miss %b want 1 0", c, o_busy, o_pc_miss); end
      step();
    end
    i_stall = 0; #1;
    checks++; if (o_pc_miss !== 1'b1 || o_pc_jmpaddr !== 32'h200) begin errors++; $display("FAIL hold_issue miss %b addr %h want 1 200", o_pc_miss, o_pc_jmpaddr); end
    checks++; if (o_pc_stall !== 1'b0 || o_flush !== 1'b1) begin errors++; $display("FAIL hold_issue_stall pcstall %b flush %b want 0 1", o_pc_stall, o_flush); end
    step(); step();
    // Equal-priority request while holding is ignored.
    i_stall = 1; i_mispred = 1; i_mispred_addr = 32'h200; step();
    i_mispred_addr = 32'h400; step();
    i_mispred = 0; i_stall = 0; #1;
    checks++; if (o_pc_jmpaddr !== 32'h200) begin errors++; $display("FAIL hold_equal_prio got %h want 200", o_pc_jmpaddr); end
    step(); step(); step();
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL hold_drain busy got %b want 0", o_busy); end
    $display("test_stall_hold done");
  endtask

`ifdef FETCH_REDIRECT_TRAP_EN
  task automatic test_trap_priority();
    i_stall = 1; i_mispred = 1; i_mispred_addr = 32'h200; step();
    i_mispred = 0; i_trap = 1; i_trap_vec = 32'h80; step();
    i_trap = 0; i_stall = 0; #1;
    checks++; if (o_pc_jmpaddr !== 32'h80 || o_pc_miss !== 1'b1) begin errors++; $display("FAIL trap_over_misp addr %h miss %b want 80 1", o_pc_jmpaddr, o_pc_miss); end
    step(); step(); step();
    i_stall = 1; i_trap = 1; i_trap_vec = 32'h80; step();
    i_trap = 0; i_mispred = 1; i_mispred_addr = 32'h200; step();
    i_mispred = 0; i_stall = 0; #1;
    checks++; if (o_pc_jmpaddr !== 32'h80) begin errors++; $display("FAIL trap_kept addr %h want 80", o_pc_jmpaddr); end
    step(); step(); step();
    $display("test_trap_priority done");
  endtask
`endif

  task automatic test_back_to_back();
    int flushes = 0;
    i_mispred = 1; i_mispred_addr = 32'h100; #1;
    flushes += int'(o_flush);
    checks++; if (o_pc_jmpaddr !== 32'h100) begin errors++; $display("FAIL b2b_first addr %h want 100", o_pc_jmpaddr); end
    step();
    i_mispred_addr = 32'h300; i_pred_jmp = 1; #1;
    flushes += int'(o_flush);
    checks++; if (o_pc_jmpaddr !== 32'h300 || o_pred_jmp !== 1'b0) begin errors++; $display("FAIL b2b_second addr %h pred %b want 300 0", o_pc_jmpaddr, o_pred_jmp); end
    step();
    // A stalled cycle does not consume the squash count.
    i_mispred = 0; i_stall = 1; #1;
    flushes += int'(o_flush);
    checks++; if (o_pred_jmp !== 1'b0 || o_busy !== 1'b1) begin errors++; $display("FAIL b2b_stall pred %b busy %b want 0 1", o_pred_jmp, o_busy); end
    step();
    i_stall = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      flushes += int'(o_flush);
      checks++; if (o_pred_jmp !== 1'b0) begin errors++; $display("FAIL b2b_mask[%0d] got %b want 0", c, o_pred_jmp); end
      step();
    end
    #1;
    checks++; if (o_pred_jmp !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("FAIL b2b_unmask pred %b busy %b want 1 0", o_pred_jmp, o_busy); end
    checks++; if (flushes !== 2) begin errors++; $display("FAIL b2b_flush_count got %0d want 2", flushes); end
    idle_inputs();
    step();
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_hold();
    i_stall = 1; i_mispred = 1; i_mispred_addr = 32'h200; step();
    i_mispred = 0; #1;
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL rhold_pending busy %b want 1", o_busy); end
    #2;
    i_stall = 0; rst_n = 0; #1;
    checks++; if (o_pc_miss !== 1'b0 || o_flush !== 1'b0 || o_pc_jmpaddr !== 32'h0) begin errors++; $display("FAIL rhold_async miss %b flush %b addr %h want 0 0 0", o_pc_miss, o_flush, o_pc_jmpaddr); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rhold_async_busy got %b want 0", o_busy); end
    step();
    rst_n = 1; #1;
    checks++; if (o_pc_miss !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL rhold_release miss %b busy %b want 0 0", o_pc_miss, o_busy); end
    step(); #1;
    checks++; if (o_pc_miss !== 1'b0 || o_flush !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL rhold_after miss %b flush %b busy %b want 0 0 0", o_pc_miss, o_flush, o_busy); end
    $display("test_reset_hold done");
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_pred_run();
    test_mispred();
    test_stall_hold();
`ifdef FETCH_REDIRECT_TRAP_EN
    test_trap_priority();
`endif
    test_back_to_back();
    test_reset_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
